// File: rtl/eth_l2_responder.sv
// Byte-stream ARP/echo responder: buffers one Ethernet frame, classifies it, streams the reply.
// Optional statistics counters are enabled by defining ETH_RESP_STATS_EN.
`timescale 1ns/1ps
module eth_l2_responder #(
    parameter int          MAX_FRAME  = 1518,
    parameter int          ADDR_W     = 11,
    parameter logic [15:0] ECHO_ETYPE = 16'h1234,
    parameter int          STAT_W     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [47:0] my_mac,
    input  logic [31:0] my_ip,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_last,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_last,
    input  logic        tx_ready,
    output logic        learn_valid,
    output logic [47:0] learn_mac,
    output logic [31:0] learn_ip,
    output logic        busy
`ifdef ETH_RESP_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_arp,
    output logic [STAT_W-1:0] stat_echo,
    output logic [STAT_W-1:0] stat_drop
`endif
);
    localparam int LW = ADDR_W + 1;

    if ((2 ** ADDR_W) < MAX_FRAME || STAT_W < 1) begin : g_bad_cfg
        $error("eth_l2_responder: ADDR_W too small for MAX_FRAME or STAT_W < 1");
    end

    typedef enum logic [1:0] {S_RECV, S_CLASS, S_ARP, S_ECHO} state_t;

    state_t         state;
    logic [LW-1:0]  len, f_idx, s1_idx, total;
    logic           ovf, s1_v, s1_last, advance, rd_en, room;
    logic [7:0]     mem [MAX_FRAME];
    logic [7:0]     hdr [42];
    logic [7:0]     rd_data, arp_data, s1_data;
    logic [5:0]     ai;
    logic [47:0]    sha, learn_mac_q;
    logic [31:0]    spa, tpa, learn_ip_q;
    logic           arp_ok, arp_req, echo_ok, tx_done;

    function automatic logic [7:0] mac_at(input logic [47:0] m, input logic [5:0] k);
        return 8'(m >> (9'd40 - {k, 3'b000}));
    endfunction

    function automatic logic [7:0] ip_at(input logic [31:0] p, input logic [5:0] k);
        return 8'(p >> (9'd24 - {k, 3'b000}));
    endfunction

    // Echo reply swaps destination and source MACs; everything else is copied in place.
    function automatic logic [LW-1:0] echo_src(input logic [LW-1:0] i);
        if (i < LW'(6))
            return i + LW'(6);
        else if (i < LW'(12))
            return i - LW'(6);
        return i;
    endfunction

    assign rx_ready = (state == S_RECV);
    assign busy     = (state != S_RECV);
    assign room     = (len < LW'(MAX_FRAME));
    assign sha      = {hdr[22], hdr[23], hdr[24], hdr[25], hdr[26], hdr[27]};
    assign spa      = {hdr[28], hdr[29], hdr[30], hdr[31]};
    assign tpa      = {hdr[38], hdr[39], hdr[40], hdr[41]};

    assign arp_ok  = !ovf && (len >= LW'(42)) && ({hdr[12], hdr[13]} == 16'h0806)
                   && ({hdr[14], hdr[15], hdr[16], hdr[17], hdr[18], hdr[19]} == 48'h0001_0800_0604)
                   && (tpa == my_ip);
    assign arp_req = arp_ok && ({hdr[20], hdr[21]} == 16'h0001);
    assign echo_ok = !ovf && !arp_ok && (len >= LW'(14)) && ({hdr[12], hdr[13]} == ECHO_ETYPE);

    // The learn pulse is shown during the classify cycle itself; the registered copy holds it afterwards.
    assign learn_valid = (state == S_CLASS) && arp_ok;
    assign learn_mac   = learn_valid ? sha : learn_mac_q;
    assign learn_ip    = learn_valid ? spa : learn_ip_q;

    assign total   = (state == S_ARP) ? LW'(42) : len;
    assign s1_last = (s1_idx == total - LW'(1));
    assign advance = !tx_valid || tx_ready;
    assign tx_done = tx_valid && tx_ready && tx_last;
    assign rd_en   = (state == S_CLASS) || ((state == S_ECHO) && advance && (f_idx < total));
    assign ai      = s1_idx[5:0];

    always_comb begin
        arp_data = 8'h00;
        if (ai < 6'd6)       arp_data = hdr[ai + 6'd22];
        else if (ai < 6'd12) arp_data = mac_at(my_mac, ai - 6'd6);
        else if (ai == 6'd12) arp_data = 8'h08;
        else if (ai == 6'd13) arp_data = 8'h06;
        else if (ai < 6'd20) arp_data = hdr[ai];
        else if (ai == 6'd21) arp_data = 8'h02;
        else if (ai == 6'd20) arp_data = 8'h00;
        else if (ai < 6'd28) arp_data = mac_at(my_mac, ai - 6'd22);
        else if (ai < 6'd32) arp_data = ip_at(my_ip, ai - 6'd28);
        else                 arp_data = hdr[ai - 6'd10];
    end

    assign s1_data = (state == S_ARP) ? arp_data : rd_data;

    // Frame storage; the read register only advances with the pipeline so a stall freezes it.
    always_ff @(posedge clk) begin
        if (state == S_RECV && rx_valid && room)
            mem[ADDR_W'(len)] <= rx_data;
        if (state == S_RECV && rx_valid && len < LW'(42))
            hdr[len[5:0]] <= rx_data;
        if (rd_en)
            rd_data <= mem[ADDR_W'(echo_src(f_idx))];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_RECV;
            len         <= '0;
            ovf         <= 1'b0;
            f_idx       <= '0;
            s1_idx      <= '0;
            s1_v        <= 1'b0;
            tx_valid    <= 1'b0;
            tx_data     <= 8'h00;
            tx_last     <= 1'b0;
            learn_mac_q <= '0;
            learn_ip_q  <= '0;
        end else begin
            case (state)
                S_RECV: begin
                    if (rx_valid) begin
                        if (room) len <= len + LW'(1);
                        else      ovf <= 1'b1;
                        if (rx_last) state <= S_CLASS;
                    end
                end
                S_CLASS: begin
                    if (arp_ok) begin
                        learn_mac_q <= sha;
                        learn_ip_q  <= spa;
                    end
                    if (arp_req || echo_ok) begin
                        state  <= arp_req ? S_ARP : S_ECHO;
                        s1_v   <= 1'b1;
                        s1_idx <= '0;
                        f_idx  <= LW'(1);
                    end else begin
                        state <= S_RECV;
                        len   <= '0;
                        ovf   <= 1'b0;
                    end
                end
                S_ARP, S_ECHO: begin
                    if (tx_done) begin
                        state    <= S_RECV;
                        len      <= '0;
                        ovf      <= 1'b0;
                        f_idx    <= '0;
                        s1_v     <= 1'b0;
                        tx_valid <= 1'b0;
                        tx_last  <= 1'b0;
                    end else if (advance) begin
                        tx_valid <= s1_v;
                        tx_data  <= s1_data;
                        tx_last  <= s1_v && s1_last;
                        if (f_idx < total) begin
                            s1_v   <= 1'b1;
                            s1_idx <= f_idx;
                            f_idx  <= f_idx + LW'(1);
                        end else begin
                            s1_v <= 1'b0;
                        end
                    end
                end
                default: state <= S_RECV;
            endcase
        end
    end

`ifdef ETH_RESP_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_arp  <= '0;
            stat_echo <= '0;
            stat_drop <= '0;
        end else begin
            if (state == S_CLASS && !arp_req && !echo_ok && stat_drop != {STAT_W{1'b1}})
                stat_drop <= stat_drop + STAT_W'(1);
            if (tx_done && state == S_ARP && stat_arp != {STAT_W{1'b1}})
                stat_arp <= stat_arp + STAT_W'(1);
            if (tx_done && state == S_ECHO && stat_echo != {STAT_W{1'b1}})
                stat_echo <= stat_echo + STAT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_eth_l2_responder.sv
// Directed self-checking bench for eth_l2_responder: ARP, echo, drops, overflow, stalls, reset abort.
`timescale 1ns/1ps
module tb_eth_l2_responder;
    localparam int MAX_FRAME = 1518;
    localparam logic [47:0] MY_MAC = 48'h02aabbccddee;
    localparam logic [31:0] MY_IP  = 32'hc0a80002;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [47:0] my_mac = MY_MAC;
    logic [31:0] my_ip  = MY_IP;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data  = 8'h00;
    logic        rx_last  = 1'b0;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_last;
    logic        tx_ready = 1'b1;
    logic        learn_valid;
    logic [47:0] learn_mac;
    logic [31:0] learn_ip;
    logic        busy;
`ifdef ETH_RESP_STATS_EN
    logic [15:0] stat_arp, stat_echo, stat_drop;
`endif

    eth_l2_responder dut (
        .clk(clk), .rst(rst), .my_mac(my_mac), .my_ip(my_ip),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_last(rx_last), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready),
        .learn_valid(learn_valid), .learn_mac(learn_mac), .learn_ip(learn_ip), .busy(busy)
`ifdef ETH_RESP_STATS_EN
        , .stat_arp(stat_arp), .stat_echo(stat_echo), .stat_drop(stat_drop)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] frame[$];
    logic [7:0] exp_q[$];
    logic       exp_l[$];
    logic [7:0] got_q[$];
    logic       last_q[$];
    int done_cnt = 0, learn_cnt = 0, hold_err = 0, cyc = 0;
    int last_done_cyc = 0, rx_first_cyc = 0;
    bit rx_arm = 0, stall_en = 0, rx_stuck = 0, hold_pending = 0;
    logic [7:0] hold_data;
    logic       hold_last;
    logic [47:0] seen_mac = '0;
    logic [31:0] seen_ip = '0;

    // TX sink and observer: drives tx_ready at the falling edge and logs what the next rising edge accepts.
    always @(negedge clk) begin
        cyc++;
        tx_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (rst) begin
            hold_pending = 0;
        end else begin
            if (hold_pending && !(tx_valid === 1'b1 && tx_data === hold_data && tx_last === hold_last))
                hold_err++;
            hold_pending = tx_valid && !tx_ready;
            hold_data = tx_data;
            hold_last = tx_last;
            if (tx_valid && tx_ready) begin
                got_q.push_back(tx_data);
                last_q.push_back(tx_last);
                if (tx_last) begin
                    done_cnt++;
                    last_done_cyc = cyc;
                end
            end
            if (learn_valid) begin
                learn_cnt++;
                seen_mac = learn_mac;
                seen_ip = learn_ip;
            end
            if (rx_arm && rx_valid && rx_ready) begin
                rx_first_cyc = cyc;
                rx_arm = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        int n;
        bit acc;
        if (rx_stuck) return;
        rx_valid = 1'b1;
        rx_data = d;
        rx_last = last;
        n = 0;
        acc = 0;
        while (!acc) begin
            @(negedge clk);
            acc = rx_ready;
            @(posedge clk);
            #1;
            n++;
            if (!acc && n >= 4000) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL rx_accept_timeout: rx_ready=%0b, required 1", rx_ready);
                rx_stuck = 1;
                acc = 1;
            end
        end
        rx_valid = 1'b0;
        rx_last = 1'b0;
    endtask

    task automatic send_frame();
        for (int i = 0; i < frame.size(); i++)
            send_byte(frame[i], i == frame.size() - 1);
    endtask

    task automatic wait_done(input int target, output bit ok);
        int n = 0;
        while (done_cnt < target && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        ok = (done_cnt >= target);
    endtask

    task automatic build_arp(input logic [15:0] op, input logic [31:0] tpa);
        logic [335:0] v;
        v = {48'hffffffffffff, 48'h020000000001, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
             op, 48'h020000000001, 32'hc0a80001, 48'h000000000000, tpa};
        frame.delete();
        for (int i = 0; i < 42; i++) frame.push_back(v[335 - 8*i -: 8]);
    endtask

    task automatic expect_arp_reply();
        logic [335:0] v;
        v = {48'h020000000001, 48'h02aabbccddee, 16'h0806, 48'h000108000604, 16'h0002,
             48'h02aabbccddee, 32'hc0a80002, 48'h020000000001, 32'hc0a80001};
        exp_q.delete();
        exp_l.delete();
        for (int i = 0; i < 42; i++) begin
            exp_q.push_back(v[335 - 8*i -: 8]);
            exp_l.push_back(i == 41);
        end
    endtask

    // Echo frame: dst = our MAC, src = 02:00:00:00:00:09, etype 1234; reply has the two MACs swapped.
    task automatic build_echo(input int n, input logic [7:0] seed, input bit add_exp);
        logic [95:0] hd, sw;
        hd = {48'h02aabbccddee, 48'h020000000009};
        sw = {48'h020000000009, 48'h02aabbccddee};
        frame.delete();
        for (int i = 0; i < 12; i++) frame.push_back(hd[95 - 8*i -: 8]);
        frame.push_back(8'h12);
        frame.push_back(8'h34);
        for (int i = 14; i < n; i++) frame.push_back(8'(i * 7) ^ seed);
        if (add_exp) begin
            for (int i = 0; i < n; i++) begin
                exp_q.push_back(i < 12 ? sw[95 - 8*i -: 8] : frame[i]);
                exp_l.push_back(i == n - 1);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        step(3);
        n_checks += 8;
        if (rx_ready !== 1'b1)   begin n_fail++; $display("[TB] FAIL reset_rx_ready: got %b, required 1", rx_ready); end
        if (tx_valid !== 1'b0)   begin n_fail++; $display("[TB] FAIL reset_tx_valid: got %b, required 0", tx_valid); end
        if (tx_last !== 1'b0)    begin n_fail++; $display("[TB] FAIL reset_tx_last: got %b, required 0", tx_last); end
        if (tx_data !== 8'h00)   begin n_fail++; $display("[TB] FAIL reset_tx_data: got %h, required 00", tx_data); end
        if (learn_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_learn_valid: got %b, required 0", learn_valid); end
        if (learn_mac !== 48'h0) begin n_fail++; $display("[TB] FAIL reset_learn_mac: got %h, required 0", learn_mac); end
        if (learn_ip !== 32'h0)  begin n_fail++; $display("[TB] FAIL reset_learn_ip: got %h, required 0", learn_ip); end
        if (busy !== 1'b0)       begin n_fail++; $display("[TB] FAIL reset_busy: got %b, required 0", busy); end
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_arp_request(input string tag);
        bit ok;
        int l0 = learn_cnt;
        int d0 = done_cnt;
        got_q.delete();
        last_q.delete();
        build_arp(16'h0001, MY_IP);
        expect_arp_reply();
        send_frame();
        wait_done(d0 + 1, ok);
        n_checks += 5;
        if (!ok) begin n_fail++; $display("[TB] FAIL %s_done: reply tx_last not seen, required within 3000 cycles", tag); end
        if (got_q.size() !== 42) begin n_fail++; $display("[TB] FAIL %s_len: got %0d bytes, required 42", tag, got_q.size()); end
        if (learn_cnt - l0 !== 1) begin n_fail++; $display("[TB] FAIL %s_learn_pulses: got %0d, required 1", tag, learn_cnt - l0); end
        if (seen_mac !== 48'h020000000001) begin n_fail++; $display("[TB] FAIL %s_learn_mac: got %h, required 020000000001", tag, seen_mac); end
        if (seen_ip !== 32'hc0a80001) begin n_fail++; $display("[TB] FAIL %s_learn_ip: got %h, required c0a80001", tag, seen_ip); end
        for (int i = 0; i < 42; i++) begin
            n_checks++;
            if (i >= got_q.size()) begin
                n_fail++;
                $display("[TB] FAIL %s_byte[%0d]: missing, required %h", tag, i, exp_q[i]);
            end else if ({last_q[i], got_q[i]} !== {exp_l[i], exp_q[i]}) begin
                n_fail++;
                $display("[TB] FAIL %s_byte[%0d]: got %h last=%b, required %h last=%b", tag, i, got_q[i], last_q[i], exp_q[i], exp_l[i]);
            end
        end
        step(1);
        n_checks++;
        if (busy !== 1'b0 || rx_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL %s_idle_after: busy=%b rx_ready=%b, required 0/1", tag, busy, rx_ready); end
    endtask

    task automatic test_echo(input int len, input logic [7:0] seed, input string tag);
        bit ok;
        int d0 = done_cnt;
        got_q.delete();
        last_q.delete();
        exp_q.delete();
        exp_l.delete();
        build_echo(len, seed, 1);
        send_frame();
        wait_done(d0 + 1, ok);
        n_checks += 2;
        if (!ok) begin n_fail++; $display("[TB] FAIL %s_done: reply tx_last not seen, required within 3000 cycles", tag); end
        if (got_q.size() !== len) begin n_fail++; $display("[TB] FAIL %s_len: got %0d bytes, required %0d", tag, got_q.size(), len); end
        for (int i = 0; i < len; i++) begin
            n_checks++;
            if (i >= got_q.size()) begin
                n_fail++;
                $display("[TB] FAIL %s_byte[%0d]: missing, required %h", tag, i, exp_q[i]);
            end else if ({last_q[i], got_q[i]} !== {exp_l[i], exp_q[i]}) begin
                n_fail++;
                $display("[TB] FAIL %s_byte[%0d]: got %h last=%b, required %h last=%b", tag, i, got_q[i], last_q[i], exp_q[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_arp_no_reply();
        int l0 = learn_cnt;
        got_q.delete();
        build_arp(16'h0002, MY_IP);
        send_frame();
        step(20);
        n_checks += 4;
        if (got_q.size() !== 0) begin n_fail++; $display("[TB] FAIL arp_reply_tx: got %0d bytes, required 0", got_q.size()); end
        if (learn_cnt - l0 !== 1) begin n_fail++; $display("[TB] FAIL arp_reply_learn: got %0d pulses, required 1", learn_cnt - l0); end
        if (learn_ip !== 32'hc0a80001) begin n_fail++; $display("[TB] FAIL arp_reply_learn_ip_hold: got %h, required c0a80001", learn_ip); end
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL arp_reply_busy: got %b, required 0", busy); end
        l0 = learn_cnt;
        build_arp(16'h0002, 32'hc0a80003);
        send_frame();
        step(20);
        n_checks += 2;
        if (got_q.size() !== 0) begin n_fail++; $display("[TB] FAIL arp_other_tpa_tx: got %0d bytes, required 0", got_q.size()); end
        if (learn_cnt - l0 !== 0) begin n_fail++; $display("[TB] FAIL arp_other_tpa_learn: got %0d pulses, required 0", learn_cnt - l0); end
    endtask

    task automatic test_overflow();
        int d0 = done_cnt;
        got_q.delete();
        build_echo(MAX_FRAME + 1, 8'h3c, 0);
        send_frame();
        step(20);
        n_checks += 3;
        if (got_q.size() !== 0) begin n_fail++; $display("[TB] FAIL overflow_tx: got %0d bytes, required 0", got_q.size()); end
        if (done_cnt !== d0) begin n_fail++; $display("[TB] FAIL overflow_replies: got %0d, required %0d", done_cnt, d0); end
        if (busy !== 1'b0 || rx_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL overflow_idle: busy=%b rx_ready=%b, required 0/1", busy, rx_ready); end
        test_echo(60, 8'h77, "post_overflow_echo");
    endtask

    task automatic test_back_to_back();
        bit ok_a, ok_b;
        int a_done = 0;
        int d0 = done_cnt;
        got_q.delete();
        last_q.delete();
        exp_q.delete();
        exp_l.delete();
        hold_err = 0;
        stall_en = 1;
        build_echo(40, 8'h5a, 1);
        send_frame();
        build_echo(20, 8'ha5, 1);
        rx_arm = 1;
        fork
            send_frame();
            begin
                wait_done(d0 + 1, ok_a);
                a_done = last_done_cyc;
            end
        join
        wait_done(d0 + 2, ok_b);
        stall_en = 0;
        n_checks += 5;
        if (!ok_a || !ok_b) begin n_fail++; $display("[TB] FAIL stall_done: got first=%0b second=%0b, required 1/1", ok_a, ok_b); end
        if (got_q.size() !== 60) begin n_fail++; $display("[TB] FAIL stall_len: got %0d bytes, required 60", got_q.size()); end
        if (hold_err !== 0) begin n_fail++; $display("[TB] FAIL stall_hold: got %0d changes while stalled, required 0", hold_err); end
        if (rx_arm !== 1'b0) begin n_fail++; $display("[TB] FAIL second_frame_accept: got none, required one accept"); end
        if (rx_first_cyc !== a_done + 1) begin n_fail++; $display("[TB] FAIL second_frame_timing: got cycle %0d, required %0d", rx_first_cyc, a_done + 1); end
        for (int i = 0; i < 60; i++) begin
            n_checks++;
            if (i >= got_q.size()) begin
                n_fail++;
                $display("[TB] FAIL stall_byte[%0d]: missing, required %h", i, exp_q[i]);
            end else if ({last_q[i], got_q[i]} !== {exp_l[i], exp_q[i]}) begin
                n_fail++;
                $display("[TB] FAIL stall_byte[%0d]: got %h last=%b, required %h last=%b", i, got_q[i], last_q[i], exp_q[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_reset_mid_reply();
        int n = 0;
        got_q.delete();
        last_q.delete();
        build_arp(16'h0001, MY_IP);
        send_frame();
        while (got_q.size() < 20 && n < 200) begin
            @(negedge clk);
            n++;
        end
        #1;
        n_checks += 4;
        if (tx_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL midreply_active: tx_valid=%b, required 1", tx_valid); end
        #1 rst = 1'b1;
        #1;
        if (tx_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midreply_async_tx_valid: got %b, required 0", tx_valid); end
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midreply_async_busy: got %b, required 0", busy); end
        if (rx_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL midreply_async_rx_ready: got %b, required 1", rx_ready); end
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        step(3);
        n_checks++;
        if (tx_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midreply_no_replay: tx_valid=%b, required 0", tx_valid); end
        test_arp_request("arp_after_reset");
    endtask

    initial begin
        test_reset();
        test_arp_request("arp_request");
        test_echo(64, 8'h00, "echo64");
        test_arp_no_reply();
        test_overflow();
        test_back_to_back();
        test_reset_mid_reply();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
